// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer: takes one {op, A, B} command from the host, replays it onto the serial ALU bus
// and returns the captured result. WAIT-state timeout abort is compiled in with ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             alu_begin,
   output logic [1:0]       alu_op_code,
   output logic [WIDTH-1:0] alu_inbus,
   input  logic [WIDTH-1:0] alu_outbus,
   input  logic             alu_end,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err
);

   // state    | meaning
   // S_IDLE   | cmd_ready high, waiting for a command
   // S_LOAD_A | alu_begin high, A on inbus
   // S_LOAD_B | alu_begin still high, B on inbus
   // S_WAIT   | B held on inbus, waiting for alu_end (or timeout)
   // S_RESP   | result held until the host takes it
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] b_q, b_nxt;
   logic             ready_nxt, begin_nxt, valid_nxt;
   logic [1:0]       op_nxt;
   logic [WIDTH-1:0] inbus_nxt, data_nxt;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt, cnt_nxt;
   logic             err_q, err_nxt;
   assign res_err = err_q;
`else
   assign res_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      b_nxt     = b_q;
      ready_nxt = cmd_ready;
      begin_nxt = alu_begin;
      op_nxt    = alu_op_code;
      inbus_nxt = alu_inbus;
      valid_nxt = res_valid;
      data_nxt  = res_data;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_nxt   = wait_cnt;
      err_nxt   = err_q;
`endif
      unique case (state)
         S_IDLE: begin
            // inbus carries A while the FSM sits in LOAD_A, so it is loaded on the accept edge
            if (cmd_valid && cmd_ready) begin
               state_nxt = S_LOAD_A;
               ready_nxt = 1'b0;
               begin_nxt = 1'b1;
               op_nxt    = cmd_op;
               inbus_nxt = cmd_a;
               b_nxt     = cmd_b;
            end
         end
         S_LOAD_A: begin
            state_nxt = S_LOAD_B;
            inbus_nxt = b_q;
         end
         S_LOAD_B: begin
            state_nxt = S_WAIT;
            begin_nxt = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
         end
         S_WAIT: begin
            if (alu_end) begin
               state_nxt = S_RESP;
               valid_nxt = 1'b1;
               data_nxt  = alu_outbus;
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_RESP;
               valid_nxt = 1'b1;
               data_nxt  = '0;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = wait_cnt + 1'b1;
            end
`endif
         end
         S_RESP: begin
            if (res_ready) begin
               state_nxt = S_IDLE;
               valid_nxt = 1'b0;
               ready_nxt = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
               err_nxt   = 1'b0;
`endif
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         b_q         <= '0;
         cmd_ready   <= 1'b1;
         alu_begin   <= 1'b0;
         alu_op_code <= '0;
         alu_inbus   <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         wait_cnt    <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         b_q         <= b_nxt;
         cmd_ready   <= ready_nxt;
         alu_begin   <= begin_nxt;
         alu_op_code <= op_nxt;
         alu_inbus   <= inbus_nxt;
         res_valid   <= valid_nxt;
         res_data    <= data_nxt;
`ifdef ALU_SEQ_TIMEOUT_EN
         wait_cnt    <= cnt_nxt;
         err_q       <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// tb_alu_cmd_sequencer: randomized host/ALU stimulus checked every cycle against a timeline model
// of the command sequence, plus a result scoreboard and literal directed checks.
module tb_alu_cmd_sequencer;
   localparam int W  = 8;
   localparam int TO = 8;

   typedef struct {logic [1:0] op; logic [7:0] a; logic [7:0] b; int d;} cmd_t;
   typedef struct {logic [7:0] data; logic err;} res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid, cmd_ready, alu_begin, alu_end, res_valid, res_ready, res_err;
   logic [1:0] cmd_op, alu_op_code;
   logic [7:0] cmd_a, cmd_b, alu_inbus, alu_outbus, res_data;

   alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_begin(alu_begin), .alu_op_code(alu_op_code),
      .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_end(alu_end), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_err(res_err));

   always #5 clk = ~clk;

   int   n_checks = 0, n_err = 0, cyc = 0, acc_cyc = 0, hs_count = 0;
   cmd_t cq[$];
   res_t sb[$];
   res_t sb_r;
   cmd_t cur;
   bit   gaps = 0, spur = 0;
   int   rr_mode = 1;

   // model: position within the current command's timeline (t=1 is the cycle after accept)
   bit         m_busy = 0, m_resp = 0, m_acc = 0;
   int         m_t = 0, m_d = 0;
   logic [7:0] m_a = 0, m_b = 0;
   logic       e_ready = 1, e_begin = 0, e_valid = 0, e_err = 0;
   logic [1:0] e_op = 0;
   logic [7:0] e_inbus = 0, e_data = 0;

   function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a * b;
         default: return (b == 0) ? 8'hFF : a / b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int d);
      cmd_t c;
      res_t r;
      bit   to;
      to = (d == 0);
`ifdef ALU_SEQ_TIMEOUT_EN
      if (d > TO) to = 1;
`endif
      c.op = op; c.a = a; c.b = b; c.d = d;
      cq.push_back(c);
      r.data = to ? 8'h00 : alu_fn(op, a, b);
      r.err  = to;
      sb.push_back(r);
   endtask

   task automatic wait_t(input int t, input string nm);
      bit ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = m_busy && !m_resp && (m_t == t);
      end
      check(nm, ok, 1);
   endtask

   task automatic wait_valid(input string nm);
      bit ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = (res_valid === 1'b1);
      end
      check(nm, ok, 1);
   endtask

   task automatic wait_idle(input int limit, input string nm);
      bit ok = 0;
      for (int k = 0; k < limit && !ok; k++) begin
         @(negedge clk);
         ok = !m_busy && (cq.size() == 0);
      end
      check(nm, ok, 1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      m_acc = 1'b0;
      if (!rst_n) begin
         m_busy = 0; m_resp = 0; m_t = 0; m_d = 0;
         e_ready = 1; e_begin = 0; e_op = 0; e_inbus = 0; e_valid = 0; e_data = 0; e_err = 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_d = 1;
            if (cq.size() > 0) begin
               cur = cq.pop_front();
               m_d = cur.d;
            end
            m_acc = 1; m_busy = 1; m_t = 1; acc_cyc = cyc;
            m_a = cmd_a; m_b = cmd_b;
            e_ready = 0; e_begin = 1; e_op = cmd_op; e_inbus = cmd_a;
         end
      end else if (!m_resp) begin
         if (m_t >= 3 && alu_end) begin
            m_resp = 1; e_valid = 1; e_data = alu_outbus; e_err = 0;
         end
`ifdef ALU_SEQ_TIMEOUT_EN
         else if (m_t - 2 == TO) begin
            m_resp = 1; e_valid = 1; e_data = 0; e_err = 1;
         end
`endif
         else begin
            m_t++;
            if (m_t == 2) e_inbus = m_b;
            if (m_t == 3) e_begin = 0;
         end
      end else if (res_ready) begin
         m_busy = 0; m_resp = 0; e_valid = 0; e_err = 0; e_ready = 1;
      end
   end

   // host and ALU side drivers, updated just after each rising edge
   initial forever begin
      @(posedge clk);
      #1;
      if (cq.size() == 0) begin
         cmd_valid = 0;
      end else if (!(cmd_valid && !m_acc)) begin
         if (!gaps || $urandom_range(0, 3) != 0) begin
            cmd_valid = 1; cmd_op = cq[0].op; cmd_a = cq[0].a; cmd_b = cq[0].b;
         end else begin
            cmd_valid = 0; cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
         end
      end
      case (rr_mode)
         0:       res_ready = 0;
         1:       res_ready = 1;
         default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_busy && !m_resp && m_d != 0 && m_t == 2 + m_d) begin
         alu_end = 1; alu_outbus = alu_fn(e_op, m_a, m_b);
      end else begin
         alu_end = spur && (!m_busy || m_resp || m_t < 3) && ($urandom_range(0, 3) == 0);
         alu_outbus = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      check("cmd_ready", cmd_ready, e_ready);
      check("alu_begin", alu_begin, e_begin);
      check("alu_op_code", alu_op_code, e_op);
      check("alu_inbus", alu_inbus, e_inbus);
      check("res_valid", res_valid, e_valid);
      check("res_data", res_data, e_data);
      check("res_err", res_err, e_err);
      if (rst_n && res_valid === 1'b1 && res_ready === 1'b1) begin
         hs_count++;
         if (sb.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL sb_extra: got result %0h expected no result", res_data);
         end else begin
            sb_r = sb.pop_front();
            check("sb_data", res_data, sb_r.data);
            check("sb_err", res_err, sb_r.err);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of run expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      logic [7:0] held;
      cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
      alu_end = 0; alu_outbus = 0; res_ready = 1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_alu_begin", alu_begin, 0);
      check("rst_alu_inbus", alu_inbus, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      rst_n = 1;

      // add 3+2, END two cycles after B
      push(2'd0, 8'd3, 8'd2, 2);
      wait_t(1, "add_accept");
      check("add_begin_c1", alu_begin, 1);
      check("add_inbus_c1", alu_inbus, 3);
      @(negedge clk);
      check("add_begin_c2", alu_begin, 1);
      check("add_inbus_c2", alu_inbus, 2);
      @(negedge clk);
      check("add_begin_c3", alu_begin, 0);
      check("add_inbus_c3", alu_inbus, 2);
      wait_valid("add_valid");
      check("add_latency", cyc - acc_cyc, 5);
      check("add_data", res_data, 5);
      wait_idle(50, "add_idle");

      push(2'd2, 8'd7, 8'd3, 3);
      wait_t(2, "mul_accept");
      check("mul_op", alu_op_code, 2);
      wait_valid("mul_valid");
      check("mul_latency", cyc - acc_cyc, 6);
      check("mul_data", res_data, 21);
      check("mul_err", res_err, 0);
      check("mul_op_resp", alu_op_code, 2);
      wait_idle(50, "mul_idle");

      // backpressure with a second command waiting
      rr_mode = 0;
      push(2'd1, 8'd20, 8'd5, 1);
      push(2'd0, 8'd1, 8'd2, 1);
      wait_valid("bp_valid");
      held = res_data;
      check("bp_data", held, 15);
      repeat (10) @(negedge clk);
      check("bp_data_held", res_data, held);
      check("bp_valid_held", res_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      rr_mode = 1;
      begin
         bit ok = 0;
         for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = (res_valid === 1'b0);
         end
         check("bp_release", ok, 1);
      end
      check("bp_ready_after_hs", cmd_ready, 1);
      wait_idle(50, "bp_idle");

      // four back-to-back commands with cmd_valid held high
      hs0 = hs_count;
      push(2'd0, 8'd10, 8'd20, 1);
      push(2'd1, 8'd5, 8'd9, 3);
      push(2'd2, 8'd16, 8'd17, 2);
      push(2'd3, 8'd100, 8'd7, 4);
      wait_idle(200, "busy_idle");
      repeat (12) @(negedge clk);
      check("busy_count", hs_count - hs0, 4);
      check("busy_sb_empty", sb.size(), 0);

      // reset during WAIT
      push(2'd0, 8'd9, 8'd9, 5);
      wait_t(4, "rst_wait");
      #2;
      rst_n = 0;
      cq.delete();
      sb.delete();
      #1;
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_begin", alu_begin, 0);
      check("mid_rst_op", alu_op_code, 0);
      check("mid_rst_inbus", alu_inbus, 0);
      check("mid_rst_data", res_data, 0);
      @(negedge clk);
      rst_n = 1;
      push(2'd0, 8'd1, 8'd1, 1);
      wait_valid("post_rst_valid");
      check("post_rst_data", res_data, 2);
      wait_idle(50, "post_rst_idle");

`ifdef ALU_SEQ_TIMEOUT_EN
      push(2'd0, 8'd4, 8'd4, 0);
      wait_valid("to_valid");
      check("to_latency", cyc - acc_cyc, 3 + TO);
      check("to_err", res_err, 1);
      check("to_data", res_data, 0);
      wait_idle(50, "to_idle");
`endif

      // randomized traffic
      gaps = 1; spur = 1; rr_mode = 2;
      for (int i = 0; i < 150; i++) begin
         int d;
`ifdef ALU_SEQ_TIMEOUT_EN
         d = $urandom_range(0, TO + 2);
`else
         d = $urandom_range(1, 6);
`endif
         push(2'($urandom), 8'($urandom), 8'($urandom), d);
      end
      wait_idle(20000, "rand_idle");
      rr_mode = 1;
      repeat (5) @(negedge clk);
      check("rand_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
